// File: rtl/i2c_master_byte_engine_pkg.sv
// Shared types for the I2C master byte engine: sequencer states, bit
// quarter phases and byte geometry.
package i2c_engine_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        LOAD,
        WBIT,
        WACK,
        RBIT,
        WAIT_RX,
        MACK,
        STOP
    } state_e;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quarter_e;

    localparam int BITS_PER_BYTE = 8;

    // Quarter that follows q within one bit time (wraps Q3 -> Q0).
    function automatic quarter_e next_quarter(input quarter_e q);
        case (q)
            Q0:      return Q1;
            Q1:      return Q2;
            Q2:      return Q3;
            Q3:      return Q0;
            default: return Q0;
        endcase
    endfunction

endpackage

// File: rtl/i2c_master_byte_engine_if.sv
// Byte streams (TX FIFO head, RX FIFO push) and open-drain bus pins of the
// I2C master byte engine.
interface i2c_master_byte_engine_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       scl_in;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;

    modport master (
        input  tx_data, tx_valid, rx_ready, scl_in, sda_in,
        output tx_ready, rx_data, rx_valid, scl_oe, sda_oe
    );

    modport slave (
        output tx_data, tx_valid, rx_ready, scl_in, sda_in,
        input  tx_ready, rx_data, rx_valid, scl_oe, sda_oe
    );

endinterface

// File: rtl/i2c_master_byte_engine_quarter_tick.sv
// Quarter-bit tick generator: counts 0..divider and fires on the terminal
// count. Held at zero while disabled; frozen (no count, no tick) while a
// slave stretches the clock.
module i2c_quarter_tick
    import i2c_engine_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             freeze,
    input  logic [DIV_W-1:0] divider,
    output logic             tick
);

    logic [DIV_W-1:0] count_r;

    assign tick = enable && !freeze && (count_r == divider);

    // Divider counter: clear when idle or on tick, hold while frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (!enable) begin
            count_r <= '0;
        end else if (freeze) begin
            count_r <= count_r;
        end else if (tick) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + DIV_W'(1);
        end
    end

endmodule

// File: rtl/i2c_master_byte_engine.sv
// I2C master bit/byte sequencer: START, address/data bytes out, optional
// read bytes in with master ACK/NACK, STOP. Open-drain enables and status
// pulses are registered.
// Optional build macro I2C_CLOCK_STRETCH_EN: freeze bit timing while a slave
// holds SCL low in the released half of a bit.
module i2c_master_byte_engine
    import i2c_engine_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_in,
    input  logic             packet_type_in,
    input  logic [CNT_W-1:0] write_length_in,
    input  logic [CNT_W-1:0] read_length_in,
    input  logic [DIV_W-1:0] clk_divider_in,
    output logic             busy,
    output logic             stop_pulse,
    output logic             slave_ack_pulse,
    output logic             slave_nack_pulse,
    output logic [CNT_W-1:0] bytes_written,
    output logic [CNT_W-1:0] bytes_read,
    i2c_master_byte_engine_if.master bus
);

    state_e           state_r, state_s;
    quarter_e         quarter_r, quarter_s;
    logic [2:0]       bit_idx_r, bit_idx_s;
    logic [7:0]       shift_r, shift_s;
    logic             sample_r, sample_s;
    logic             is_read_r, is_read_s;
    logic [CNT_W-1:0] wlen_r, wlen_s, rlen_r, rlen_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic [CNT_W-1:0] bw_r, bw_s, br_r, br_s;
    logic [7:0]       rx_data_r, rx_data_s;
    logic             scl_oe_r, scl_oe_s, sda_oe_r, sda_oe_s;
    logic             tx_ready_r, tx_ready_s, rx_valid_r, rx_valid_s;
    logic             stop_r, stop_s, ack_r, ack_s, nack_r, nack_s;
    logic             tick_s, freeze_s, enable_s, bit_end_s, sample_tick_s;
    logic             low_phase_s;

    localparam logic [2:0] MSB_IDX = 3'(BITS_PER_BYTE - 1);

    assign enable_s      = (state_r != IDLE) && (state_r != LOAD) && (state_r != WAIT_RX);
    assign bit_end_s     = tick_s && (quarter_r == Q3);
    assign sample_tick_s = tick_s && (quarter_r == Q2);

`ifdef I2C_CLOCK_STRETCH_EN
    assign freeze_s = ((quarter_r == Q2) || (quarter_r == Q3)) && !scl_oe_r && !bus.scl_in;
`else
    logic unused_scl_s;
    assign unused_scl_s = bus.scl_in;
    assign freeze_s     = 1'b0;
`endif

    i2c_quarter_tick #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable_s),
        .freeze  (freeze_s),
        .divider (div_r),
        .tick    (tick_s)
    );

    // Sequencer next state, datapath updates and status pulses.
    always_comb begin
        state_s    = state_r;
        quarter_s  = tick_s ? next_quarter(quarter_r) : quarter_r;
        bit_idx_s  = bit_idx_r;
        shift_s    = shift_r;
        sample_s   = sample_r;
        is_read_s  = is_read_r;
        wlen_s     = wlen_r;
        rlen_s     = rlen_r;
        div_s      = div_r;
        bw_s       = bw_r;
        br_s       = br_r;
        rx_data_s  = rx_data_r;
        tx_ready_s = 1'b0;
        rx_valid_s = 1'b0;
        stop_s     = 1'b0;
        ack_s      = 1'b0;
        nack_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_in) begin
                    is_read_s = packet_type_in;
                    wlen_s    = (write_length_in == '0) ? CNT_W'(1) : write_length_in;
                    rlen_s    = read_length_in;
                    div_s     = clk_divider_in;
                    bw_s      = '0;
                    br_s      = '0;
                    quarter_s = Q0;
                    state_s   = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = START;
                end
            end
            LOAD: begin
                if (bus.tx_valid) begin
                    tx_ready_s = 1'b1;
                    shift_s    = bus.tx_data;
                    bit_idx_s  = MSB_IDX;
                    state_s    = WBIT;
                end else begin
                    state_s = LOAD;
                end
            end
            WBIT: begin
                if (bit_end_s && (bit_idx_r == 3'd0)) begin
                    state_s = WACK;
                end else if (bit_end_s) begin
                    bit_idx_s = bit_idx_r - 3'd1;
                    shift_s   = {shift_r[6:0], 1'b0};
                end else begin
                    state_s = WBIT;
                end
            end
            WACK: begin
                if (sample_tick_s) begin
                    sample_s = bus.sda_in;
                end else if (bit_end_s && sample_r) begin
                    nack_s  = 1'b1;
                    state_s = STOP;
                end else if (bit_end_s) begin
                    ack_s     = 1'b1;
                    bw_s      = bw_r + CNT_W'(1);
                    bit_idx_s = MSB_IDX;
                    if (!is_read_r) begin
                        state_s = (bw_s < wlen_r) ? LOAD : STOP;
                    end else begin
                        state_s = (rlen_r != '0) ? RBIT : STOP;
                    end
                end else begin
                    state_s = WACK;
                end
            end
            RBIT: begin
                if (sample_tick_s) begin
                    shift_s = {shift_r[6:0], bus.sda_in};
                end else if (bit_end_s && (bit_idx_r == 3'd0) && bus.rx_ready) begin
                    rx_data_s  = shift_r;
                    rx_valid_s = 1'b1;
                    br_s       = br_r + CNT_W'(1);
                    state_s    = MACK;
                end else if (bit_end_s && (bit_idx_r == 3'd0)) begin
                    state_s = WAIT_RX;
                end else if (bit_end_s) begin
                    bit_idx_s = bit_idx_r - 3'd1;
                end else begin
                    state_s = RBIT;
                end
            end
            WAIT_RX: begin
                if (bus.rx_ready) begin
                    rx_data_s  = shift_r;
                    rx_valid_s = 1'b1;
                    br_s       = br_r + CNT_W'(1);
                    state_s    = MACK;
                end else begin
                    state_s = WAIT_RX;
                end
            end
            MACK: begin
                if (bit_end_s) begin
                    bit_idx_s = MSB_IDX;
                    state_s   = (br_r < rlen_r) ? RBIT : STOP;
                end else begin
                    state_s = MACK;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    stop_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Open-drain levels for the phase the sequencer is entering.
    always_comb begin
        low_phase_s = (quarter_s == Q0) || (quarter_s == Q1);
        scl_oe_s    = 1'b0;
        sda_oe_s    = sda_oe_r;
        case (state_s)
            IDLE: begin
                scl_oe_s = 1'b0;
                sda_oe_s = 1'b0;
            end
            START: begin
                scl_oe_s = (quarter_s == Q3);
                sda_oe_s = (quarter_s == Q2) || (quarter_s == Q3);
            end
            LOAD, WAIT_RX: begin
                scl_oe_s = 1'b1;
            end
            WBIT: begin
                scl_oe_s = low_phase_s;
                sda_oe_s = !shift_s[7];
            end
            WACK, RBIT: begin
                scl_oe_s = low_phase_s;
                sda_oe_s = 1'b0;
            end
            MACK: begin
                scl_oe_s = low_phase_s;
                sda_oe_s = (br_s < rlen_s);
            end
            STOP: begin
                scl_oe_s = low_phase_s;
                sda_oe_s = (quarter_s != Q3);
            end
            default: begin
                scl_oe_s = 1'b0;
                sda_oe_s = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset releases the bus at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            quarter_r  <= Q0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            sample_r   <= 1'b1;
            is_read_r  <= 1'b0;
            wlen_r     <= '0;
            rlen_r     <= '0;
            div_r      <= '0;
            bw_r       <= '0;
            br_r       <= '0;
            rx_data_r  <= 8'h00;
            scl_oe_r   <= 1'b0;
            sda_oe_r   <= 1'b0;
            tx_ready_r <= 1'b0;
            rx_valid_r <= 1'b0;
            stop_r     <= 1'b0;
            ack_r      <= 1'b0;
            nack_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            quarter_r  <= quarter_s;
            bit_idx_r  <= bit_idx_s;
            shift_r    <= shift_s;
            sample_r   <= sample_s;
            is_read_r  <= is_read_s;
            wlen_r     <= wlen_s;
            rlen_r     <= rlen_s;
            div_r      <= div_s;
            bw_r       <= bw_s;
            br_r       <= br_s;
            rx_data_r  <= rx_data_s;
            scl_oe_r   <= scl_oe_s;
            sda_oe_r   <= sda_oe_s;
            tx_ready_r <= tx_ready_s;
            rx_valid_r <= rx_valid_s;
            stop_r     <= stop_s;
            ack_r      <= ack_s;
            nack_r     <= nack_s;
        end
    end

    assign busy             = (state_r != IDLE);
    assign stop_pulse       = stop_r;
    assign slave_ack_pulse  = ack_r;
    assign slave_nack_pulse = nack_r;
    assign bytes_written    = bw_r;
    assign bytes_read       = br_r;
    assign bus.tx_ready     = tx_ready_r;
    assign bus.rx_data      = rx_data_r;
    assign bus.rx_valid     = rx_valid_r;
    assign bus.scl_oe       = scl_oe_r;
    assign bus.sda_oe       = sda_oe_r;

endmodule
